// File: rtl/spi_master_ctrl.sv
// SPI master frame controller: one command per frame (control bit, 10-bit op/data shift),
// optional read-data wait and 8-bit receive, followed by a ss_n-high gap.
module spi_master_ctrl #(
  parameter int RD_LATENCY = 2,
  parameter int IDLE_GAP   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       ss_n,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CTRL  = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] RECV  = 3'd4;
  localparam logic [2:0] GAP   = 3'd5;

  localparam logic [3:0] WAIT_LAST = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;
  localparam logic [3:0] GAP_LAST  = 4'(IDLE_GAP - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] sr_q, sr_d;
  logic [1:0] op_q, op_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       rd_valid_q, rd_valid_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = ~cmd_ready;
  assign ss_n      = ss_n_q;
  assign mosi      = mosi_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

  // Pin outputs are computed one cycle ahead so they come straight from flops.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    op_d       = op_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ss_n_d     = ss_n_q;
    mosi_d     = 1'b0;
    case (state_q)
      IDLE: begin
        ss_n_d = 1'b1;
        if (cmd_valid) begin
          state_d = CTRL;
          sr_d    = {cmd_op, cmd_data};
          op_d    = cmd_op;
          cnt_d   = 4'd0;
          ss_n_d  = 1'b0;
          mosi_d  = cmd_op[1];
        end
      end
      CTRL: begin
        state_d = SHIFT;
        cnt_d   = 4'd0;
        mosi_d  = sr_q[9];
        sr_d    = {sr_q[8:0], 1'b0};
      end
      SHIFT: begin
        if (cnt_q == 4'd9) begin
          cnt_d = 4'd0;
          if (op_q == 2'b11) begin
            state_d = (RD_LATENCY == 0) ? RECV : WAIT;
            ss_n_d  = 1'b0;
          end else begin
            state_d = GAP;
            ss_n_d  = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q + 4'd1;
          mosi_d = sr_q[9];
          sr_d   = {sr_q[8:0], 1'b0};
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = RECV;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RECV: begin
        rx_d = {rx_q[6:0], miso};
        if (cnt_q == 4'd7) begin
          state_d    = GAP;
          cnt_d      = 4'd0;
          rd_data_d  = {rx_q[6:0], miso};
          rd_valid_d = 1'b1;
          ss_n_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      GAP: begin
        ss_n_d = 1'b1;
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        ss_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      sr_q       <= 10'd0;
      op_q       <= 2'b00;
      rx_q       <= 8'h00;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      op_q       <= op_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (read latency 2 and 0), each with a
// register-file SPI slave model and a frame monitor popping a shared scoreboard.
module tb_spi_master_ctrl;

  localparam int LAT0 = 2;
  localparam int LAT1 = 0;
  localparam int GAP  = 1;

  typedef struct {
    int          len;
    logic [31:0] bits;
    bit          rd;
    logic [7:0]  rdat;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic [1:0]      cv;
  logic [1:0]      rdy;
  logic [1:0][1:0] cop;
  logic [1:0][7:0] cdat;
  logic [1:0]      rdv;
  logic [1:0][7:0] rdat;
  logic [1:0]      busy;
  logic [1:0]      ss_n;
  logic [1:0]      mosi;

  exp_t       sbq[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         cycnt = 0;
  bit         b2b = 1'b0;
  bit         have_last = 1'b0;
  int         last_acc = 0;
  int         last_len = 0;
  logic [7:0] emem [2][256];
  logic [7:0] eaddr [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycnt <= cycnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? LAT0 : LAT1;
    logic       miso_g;
    int         cyc;
    logic [9:0] sh;
    logic [7:0] saddr;
    logic [7:0] rbyte;
    logic [7:0] smem [256];

    spi_master_ctrl #(.RD_LATENCY(L), .IDLE_GAP(GAP)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cmd_valid(cv[g]),
      .cmd_ready(rdy[g]),
      .cmd_op   (cop[g]),
      .cmd_data (cdat[g]),
      .rd_valid (rdv[g]),
      .rd_data  (rdat[g]),
      .busy     (busy[g]),
      .ss_n     (ss_n[g]),
      .mosi     (mosi[g]),
      .miso     (miso_g)
    );

    // Slave: decodes the mosi stream, answers read-data L cycles after the last mosi bit.
    initial begin
      miso_g = 1'b0; cyc = 0; sh = '0; saddr = '0; rbyte = '0;
      for (int i = 0; i < 256; i++) smem[i] = 8'h00;
      forever begin
        @(negedge clk);
        if (!rst_n || ss_n[g]) begin
          cyc = 0;
          miso_g = 1'b0;
        end else begin
          if (cyc >= 1 && cyc <= 10) sh = {sh[8:0], mosi[g]};
          if (cyc == 10) begin
            case (sh[9:8])
              2'b00:   saddr = sh[7:0];
              2'b01:   smem[saddr] = sh[7:0];
              2'b10:   saddr = sh[7:0];
              default: rbyte = smem[saddr];
            endcase
          end
          if (cyc >= 11 + L && cyc <= 18 + L) miso_g = rbyte[7 - (cyc - 11 - L)];
          else miso_g = 1'b0;
          cyc++;
        end
      end
    end

    // Monitor: collects each ss_n-low frame and compares it with the scoreboard head.
    initial begin
      bit          inf;
      int          len;
      logic [31:0] bits;
      exp_t        e;
      inf = 1'b0; len = 0; bits = '0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          inf = 1'b0;
        end else if (!ss_n[g]) begin
          if (!inf) begin
            inf = 1'b1; len = 0; bits = '0;
          end
          len++;
          bits = {bits[30:0], mosi[g]};
          if (rdv[g]) chk("rdv_in_frame", rdv[g], 0);
        end else if (inf) begin
          inf = 1'b0;
          chk("gap_busy", busy[g], 1);
          if (sbq.size() == 0) begin
            chk("sb_extra_frame", len, 0);
          end else begin
            e = sbq.pop_front();
            chk("frame_len", len, e.len);
            chk("mosi_bits", bits, e.bits);
            chk("rd_valid", rdv[g], e.rd);
            if (e.rd) chk("rd_data", rdat[g], e.rdat);
          end
        end else if (rdv[g]) begin
          chk("rdv_spur", rdv[g], 0);
        end
      end
    end
  end

  task automatic send(input int k, input logic [1:0] op, input logic [7:0] d,
                      input bit push, input bit hold);
    exp_t e;
    int   n;
    logic b;
    n = 0;
    e.len = (op == 2'b11) ? 19 + lat_of(k) : 11;
    e.bits = '0; e.rd = 1'b0; e.rdat = '0;
    for (int i = 0; i < e.len; i++) begin
      if (i == 0) b = op[1];
      else if (i <= 2) b = op[2 - i];
      else if (i <= 10) b = d[10 - i];
      else b = 1'b0;
      e.bits = {e.bits[30:0], b};
    end
    case (op)
      2'b00: eaddr[k] = d;
      2'b01: emem[k][eaddr[k]] = d;
      2'b10: eaddr[k] = d;
      default: begin e.rd = 1'b1; e.rdat = emem[k][eaddr[k]]; end
    endcase
    cv[k] = 1'b1; cop[k] = op; cdat[k] = d;
    while (!rdy[k] && n < 100) begin @(negedge clk); n++; end
    if (!rdy[k]) chk("accept_timeout", rdy[k], 1);
    @(posedge clk);
    if (push) sbq.push_back(e);
    #1;
    if (b2b && have_last) chk("acc_space", cycnt - last_acc, last_len + GAP + 1);
    last_acc = cycnt; last_len = e.len; have_last = 1'b1;
    if (!hold) begin
      cv[k] = 1'b0; cop[k] = ~op; cdat[k] = ~d;
    end
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (busy[k] && n < 100) begin @(negedge clk); n++; end
    if (busy[k]) chk("idle_timeout", busy[k], 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; cv = '0; cop = '0; cdat = '0;
    for (int k = 0; k < 2; k++) begin
      eaddr[k] = 8'h00;
      for (int i = 0; i < 256; i++) emem[k][i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ss_n", ss_n[k], 1);
      chk("rst_mosi", mosi[k], 0);
      chk("rst_rd_valid", rdv[k], 0);
      chk("rst_rd_data", rdat[k], 0);
      chk("rst_ready", rdy[k], 1);
      chk("rst_busy", busy[k], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Write addr A5, write data 3C there, read it back (latency 2).
    send(0, 2'b00, 8'hA5, 1, 0); wait_idle(0);
    send(0, 2'b01, 8'h3C, 1, 0); wait_idle(0);
    send(0, 2'b10, 8'hA5, 1, 0); wait_idle(0);
    send(0, 2'b11, 8'h00, 1, 0); wait_idle(0);

    // Back-to-back with cmd_valid held high.
    b2b = 1'b1; have_last = 1'b0;
    send(0, 2'b00, 8'h10, 1, 1);
    send(0, 2'b01, 8'hFF, 1, 1);
    send(0, 2'b10, 8'h10, 1, 1);
    send(0, 2'b11, 8'h00, 1, 0);
    wait_idle(0);
    b2b = 1'b0;

    // Request pulsed during SHIFT must be dropped.
    send(0, 2'b01, 8'h77, 1, 0);
    repeat (3) @(negedge clk);
    cv[0] = 1'b1; cop[0] = 2'b00; cdat[0] = 8'h99;
    chk("shift_ready", rdy[0], 0);
    @(negedge clk);
    chk("shift_ready2", rdy[0], 0);
    cv[0] = 1'b0;
    wait_idle(0);

    // Reset during the 5th RECV cycle abandons the read.
    send(0, 2'b11, 8'h00, 0, 0);
    repeat (17) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ss_n", ss_n[0], 1);
    chk("mid_rst_mosi", mosi[0], 0);
    chk("mid_rst_rd_valid", rdv[0], 0);
    chk("mid_rst_rd_data", rdat[0], 0);
    chk("mid_rst_ready", rdy[0], 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_rd_data", rdat[0], 0);
    send(0, 2'b11, 8'h00, 1, 0);
    chk("first_edge_accept", busy[0], 1);
    wait_idle(0);

    // Zero read latency instance.
    send(1, 2'b00, 8'h33, 1, 0); wait_idle(1);
    send(1, 2'b01, 8'hC3, 1, 0); wait_idle(1);
    send(1, 2'b10, 8'h33, 1, 0); wait_idle(1);
    send(1, 2'b11, 8'h00, 1, 0); wait_idle(1);
    send(1, 2'b01, 8'h5A, 1, 0); wait_idle(1);
    send(1, 2'b11, 8'h00, 1, 0); wait_idle(1);

    repeat (5) @(negedge clk);
    chk("sb_drain", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter: RD_LATENCY, default 2, cycles from last MOSI bit of a read-data frame to first valid MISO bit (legal range 0..15).
REQ-002 Parameter: IDLE_GAP, default 1, cycles ss_n held high between frames (legal range 1..15).
REQ-003 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: cmd_valid  input  1  command request.
REQ-006 Port: cmd_ready  output  1  controller can accept a command.
REQ-007 Port: cmd_op  input  2  opcode: 00 write addr, 01 write data, 10 read addr, 11 read data.
REQ-008 Port: cmd_data  input  8  address or data byte.
REQ-009 Port: rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-010 Port: rd_data  output  8  byte received on miso.
REQ-011 Port: busy  output  1  frame or gap in progress.
REQ-012 Port: ss_n  output  1  slave select, active-low.
REQ-013 Port: mosi  output  1  serial data to slave.
REQ-014 Port: miso  input  1  serial data from slave.

Function
REQ-015 FSM states SHALL be IDLE, CTRL, SHIFT, WAIT, RECV, GAP.
REQ-016 cmd_ready SHALL equal (state == IDLE); busy SHALL equal its inverse.
REQ-017 A command SHALL be accepted on a rising edge with cmd_valid & cmd_ready; cmd_op and cmd_data captured into a 10-bit shift register {cmd_op, cmd_data}.
REQ-018 cmd_valid while busy SHALL be ignored; no queuing; captured fields SHALL be unaffected by input changes after acceptance.
REQ-019 IDLE -> CTRL on acceptance; in CTRL ss_n = 0 and mosi = cmd_op[1] (0 write, 1 read) for exactly 1 cycle.
REQ-020 CTRL -> SHIFT; SHIFT lasts 10 cycles, mosi driving captured bits MSB first (op[1], op[0], data[7..0]), ss_n = 0.
REQ-021 After SHIFT: op != 11 -> GAP; op == 11 -> WAIT (or directly RECV if RD_LATENCY = 0).
REQ-022 WAIT SHALL last RD_LATENCY cycles with ss_n = 0, mosi = 0.
REQ-023 RECV SHALL last 8 cycles with ss_n = 0, mosi = 0, sampling miso every rising edge into rd_data MSB first.
REQ-024 On the edge after the 8th sample: rd_valid = 1 for exactly one cycle, rd_data holds the byte until the next read-data completion, state -> GAP.
REQ-025 GAP SHALL hold ss_n = 1, mosi = 0 for IDLE_GAP cycles, then -> IDLE.
REQ-026 Frame lengths (ss_n low): 11 cycles for ops 00/01/10; 19 + RD_LATENCY cycles for op 11.
REQ-027 ss_n, mosi, rd_valid, rd_data SHALL be driven from registers (no combinational path from inputs).
REQ-028 Minimum accept-to-accept spacing: frame length + IDLE_GAP + 1 cycles.

Reset
REQ-029 While rst_n = 0: state IDLE, ss_n = 1, mosi = 0, rd_valid = 0, rd_data = 8'h00, cmd_ready = 1, busy = 0, counters cleared.
REQ-030 Reset mid-frame SHALL raise ss_n immediately (asynchronously), abandon the frame, and produce no rd_valid.
REQ-031 After rst_n rises, first command acceptance SHALL be possible on the first rising edge.

Verification
REQ-032 Write addr: op 00, data 8'hA5 -> ss_n low 11 cycles, mosi = 0,0,0,1,0,1,0,0,1,0,1, then ss_n high IDLE_GAP cycles, no rd_valid.
REQ-033 Read data, RD_LATENCY = 2, miso model returns 8'h3C -> mosi = 1,1,1 then data bits, ss_n low 21 cycles, rd_valid single pulse with rd_data = 8'h3C.
REQ-034 Back-to-back: cmd_valid held high with 4 commands (00 8'h10, 01 8'hFF, 10 8'h10, 11 8'h00) -> each accepted only in IDLE, gaps exactly IDLE_GAP, connected RAM+slave returns 8'hFF.
REQ-035 Busy drop: cmd_valid pulsed during SHIFT -> not accepted, frame unchanged, cmd_ready stays 0 until IDLE.
REQ-036 Reset at cycle 5 of RECV -> ss_n = 1 in same cycle, rd_valid never asserts, rd_data = 8'h00, next command runs normally.
REQ-037 RD_LATENCY = 0 -> RECV directly follows SHIFT, ss_n low 19 cycles, correct byte captured.
